// File: rtl/apple1_pkg.sv
// Shared constants for the Apple-1 PIA keyboard/display interface.
package apple1_pkg;

    // Default base of the four-register window (KBD, KBDCR, DSP, DSPCR).
    localparam logic [15:0] DEFAULT_BASE_ADDR = 16'hD010;

    // Register offsets selected by AB[1:0].
    localparam logic [1:0] OFS_KBD   = 2'd0;
    localparam logic [1:0] OFS_KBDCR = 2'd1;
    localparam logic [1:0] OFS_DSP   = 2'd2;
    localparam logic [1:0] OFS_DSPCR = 2'd3;

    // ASCII range folded to upper case on keyboard entry.
    localparam logic [6:0] CHR_a      = 7'h61;
    localparam logic [6:0] CHR_z      = 7'h7A;
    localparam logic [6:0] CASE_DELTA = 7'h20;

    // Map 'a'..'z' to 'A'..'Z'; every other code passes through untouched.
    function automatic logic [6:0] to_upper(input logic [6:0] c);
        logic [6:0] r;
        r = c;
        if ((c >= CHR_a) && (c <= CHR_z)) begin
            r = c - CASE_DELTA;
        end
        return r;
    endfunction

endpackage

// File: rtl/apple1_kbd_fifo.sv
// Small 7-bit keystroke FIFO. Push into a full FIFO and pop from an empty
// one are ignored, so callers may present requests without pre-gating.
module apple1_kbd_fifo #(
    parameter int KBD_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [6:0]                 din,
    output logic [6:0]                 dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(KBD_DEPTH):0] count
);

    localparam int PW = $clog2(KBD_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(KBD_DEPTH);

    logic [6:0]    mem_q [KBD_DEPTH];
    logic [6:0]    mem_d [KBD_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_FULL);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy; pointers wrap naturally.
    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards any buffered keys.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/apple1_pia.sv
// Apple-1 PIA subset: keyboard FIFO and display latch behind a 4-register
// bus window with one-cycle registered read data.
module apple1_pia
    import apple1_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          KBD_DEPTH = 4,
    parameter bit          UPPERCASE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] AB,
    input  logic [7:0]  DO,
    input  logic        WE,
    output logic [7:0]  pia_DI,
    output logic        pia_sel,
    input  logic [6:0]  kbd_data,
    input  logic        kbd_valid,
    output logic        kbd_ready,
    output logic [6:0]  dsp_data,
    output logic        dsp_valid,
    input  logic        dsp_ready
);

    localparam int CW = $clog2(KBD_DEPTH) + 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(KBD_DEPTH);

    logic [7:0]    pia_di_q, pia_di_d;
    logic          pia_sel_q, pia_sel_d;
    logic          kbd_ready_q, kbd_ready_d;
    logic [6:0]    dsp_data_q, dsp_data_d;
    logic          dsp_valid_q, dsp_valid_d;
    logic [6:0]    kbdcr_q, kbdcr_d;
    logic [6:0]    dspcr_q, dspcr_d;

    logic          hit;
    logic [1:0]    ofs;
    logic          bus_rd;
    logic          bus_wr;
    logic          fifo_push;
    logic          fifo_pop;
    logic [6:0]    fifo_din;
    logic [6:0]    fifo_dout;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] count_next;
    logic [7:0]    rd_val;
    logic          unused_do7;

    assign unused_do7 = DO[7];

    assign pia_DI    = pia_di_q;
    assign pia_sel   = pia_sel_q;
    assign kbd_ready = kbd_ready_q;
    assign dsp_data  = dsp_data_q;
    assign dsp_valid = dsp_valid_q;

    apple1_kbd_fifo #(
        .KBD_DEPTH(KBD_DEPTH)
    ) u_kbd_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    // Address decode plus keyboard push/pop; a pop on an empty FIFO is suppressed.
    always_comb begin
        hit       = (AB[15:2] == BASE_ADDR[15:2]);
        ofs       = AB[1:0];
        bus_rd    = hit && !WE;
        bus_wr    = hit && WE;
        fifo_din  = UPPERCASE ? to_upper(kbd_data) : kbd_data;
        fifo_push = kbd_valid && kbd_ready_q && !fifo_full;
        fifo_pop  = bus_rd && (ofs == OFS_KBD) && !fifo_empty;
        case ({fifo_push, fifo_pop})
            2'b10:   count_next = fifo_count + CNT_ONE;
            2'b01:   count_next = fifo_count - CNT_ONE;
            default: count_next = fifo_count;
        endcase
        kbd_ready_d = (count_next != CNT_FULL);
    end

    // Read mux sampled in the request cycle and presented one cycle later.
    always_comb begin
        rd_val = 8'h00;
        case (ofs)
            OFS_KBD:   rd_val = fifo_empty ? 8'h00 : {1'b1, fifo_dout};
            OFS_KBDCR: rd_val = {!fifo_empty, kbdcr_q};
            OFS_DSP:   rd_val = {dsp_valid_q, dsp_data_q};
            OFS_DSPCR: rd_val = {1'b0, dspcr_q};
            default:   rd_val = 8'h00;
        endcase
        pia_sel_d = bus_rd;
        pia_di_d  = bus_rd ? rd_val : pia_di_q;
    end

    // Control-register writes and the display latch; a DSP write only lands
    // when nothing is pending, judged on the pre-edge valid flag.
    always_comb begin
        kbdcr_d     = kbdcr_q;
        dspcr_d     = dspcr_q;
        dsp_data_d  = dsp_data_q;
        dsp_valid_d = dsp_valid_q;
        if (bus_wr && (ofs == OFS_KBDCR)) begin
            kbdcr_d = DO[6:0];
        end
        if (bus_wr && (ofs == OFS_DSPCR)) begin
            dspcr_d = DO[6:0];
        end
        if (bus_wr && (ofs == OFS_DSP) && !dsp_valid_q) begin
            dsp_data_d  = DO[6:0];
            dsp_valid_d = 1'b1;
        end else if (dsp_valid_q && dsp_ready) begin
            dsp_valid_d = 1'b0;
        end
    end

    // Registered outputs and control state.
    always_ff @(posedge clk) begin
        if (reset) begin
            pia_di_q    <= 8'h00;
            pia_sel_q   <= 1'b0;
            kbd_ready_q <= 1'b0;
            dsp_data_q  <= 7'h00;
            dsp_valid_q <= 1'b0;
            kbdcr_q     <= 7'h00;
            dspcr_q     <= 7'h00;
        end else begin
            pia_di_q    <= pia_di_d;
            pia_sel_q   <= pia_sel_d;
            kbd_ready_q <= kbd_ready_d;
            dsp_data_q  <= dsp_data_d;
            dsp_valid_q <= dsp_valid_d;
            kbdcr_q     <= kbdcr_d;
            dspcr_q     <= dspcr_d;
        end
    end

endmodule

// File: tb/tb_apple1_pia.sv
// Directed bench for apple1_pia with a read-data scoreboard.
module tb_apple1_pia;

    localparam logic [15:0] IDLE_ADDR = 16'h0000;

    logic        clk;
    logic        reset;
    logic [15:0] AB;
    logic [7:0]  DO;
    logic        WE;
    logic [7:0]  pia_DI;
    logic        pia_sel;
    logic [6:0]  kbd_data;
    logic        kbd_valid;
    logic        kbd_ready;
    logic [6:0]  dsp_data;
    logic        dsp_valid;
    logic        dsp_ready;

    int          nChecks = 0;
    int          nPass   = 0;
    logic [7:0]  expQ[$];

    apple1_pia #(
        .BASE_ADDR(16'hD010),
        .KBD_DEPTH(4),
        .UPPERCASE(1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .AB        (AB),
        .DO        (DO),
        .WE        (WE),
        .pia_DI    (pia_DI),
        .pia_sel   (pia_sel),
        .kbd_data  (kbd_data),
        .kbd_valid (kbd_valid),
        .kbd_ready (kbd_ready),
        .dsp_data  (dsp_data),
        .dsp_valid (dsp_valid),
        .dsp_ready (dsp_ready)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    // Drive one bus cycle, then return the bus to an unmapped idle address.
    task automatic applyStimulus(input logic [15:0] addr, input logic we, input logic [7:0] data);
        AB = addr;
        WE = we;
        DO = data;
        tick();
        AB = IDLE_ADDR;
        WE = 1'b0;
        DO = 8'h00;
    endtask

    // Pop the scoreboard and compare against the registered read result.
    task automatic checkRead(input string tag);
        logic [7:0] e;
        if (expQ.size() == 0) begin
            nChecks++;
            $error("[TB] FAIL %s: observed=read expected=scoreboard entry", tag);
        end else begin
            e = expQ.pop_front();
            checkOutput({tag, "_sel"}, {7'b0, pia_sel}, 8'h01);
            checkOutput(tag, pia_DI, e);
        end
    endtask

    // Issue a read, recording its expected data at drive time.
    task automatic busRead(input logic [15:0] addr, input logic [7:0] exp, input string tag);
        expQ.push_back(exp);
        applyStimulus(addr, 1'b0, 8'h00);
        checkRead(tag);
    endtask

    // Offer one key to the FIFO for a single cycle.
    task automatic pushKey(input logic [6:0] key);
        kbd_data  = key;
        kbd_valid = 1'b1;
        tick();
        kbd_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        AB        = IDLE_ADDR;
        DO        = 8'h00;
        WE        = 1'b0;
        kbd_data  = 7'h00;
        kbd_valid = 1'b0;
        dsp_ready = 1'b0;
        tick();
        tick();

        // Reset state
        checkOutput("rst_sel", {7'b0, pia_sel}, 8'h00);
        checkOutput("rst_di", pia_DI, 8'h00);
        checkOutput("rst_kbd_ready", {7'b0, kbd_ready}, 8'h00);
        checkOutput("rst_dsp_valid", {7'b0, dsp_valid}, 8'h00);
        checkOutput("rst_dsp_data", {1'b0, dsp_data}, 8'h00);
        reset = 1'b0;

        // First read after reset
        busRead(16'hD011, 8'h00, "kbdcr_after_rst");
        checkOutput("kbd_ready_up", {7'b0, kbd_ready}, 8'h01);
        checkOutput("dsp_valid_idle", {7'b0, dsp_valid}, 8'h00);
        applyStimulus(IDLE_ADDR, 1'b0, 8'h00);
        checkOutput("idle_sel", {7'b0, pia_sel}, 8'h00);
        checkOutput("idle_di_hold", pia_DI, 8'h00);

        // Lower-case key folded to upper case and popped by a KBD read
        pushKey(7'h61);
        busRead(16'hD011, 8'h80, "kbdcr_nonempty");
        busRead(16'hD010, 8'hC1, "kbd_pop_a");
        busRead(16'hD011, 8'h00, "kbdcr_empty");

        // Fill to depth; fifth key is held off
        for (int i = 0; i < 4; i++) pushKey(7'h41 + 7'(i));
        checkOutput("full_ready_low", {7'b0, kbd_ready}, 8'h00);
        kbd_data  = 7'h45;
        kbd_valid = 1'b1;
        tick();
        kbd_valid = 1'b0;
        checkOutput("held_ready_low", {7'b0, kbd_ready}, 8'h00);
        busRead(16'hD011, 8'h80, "kbdcr_full");
        busRead(16'hD010, 8'hC1, "pop_A");
        busRead(16'hD010, 8'hC2, "pop_B");
        busRead(16'hD010, 8'hC3, "pop_C");
        busRead(16'hD010, 8'hC4, "pop_D");
        checkOutput("drained_ready", {7'b0, kbd_ready}, 8'h01);
        pushKey(7'h45);
        busRead(16'hD010, 8'hC5, "pop_E");
        busRead(16'hD011, 8'h00, "kbdcr_drained");

        // Display latch: second write dropped while pending
        applyStimulus(16'hD012, 1'b1, 8'h8D);
        applyStimulus(16'hD012, 1'b1, 8'hC8);
        checkOutput("dsp_data_kept", {1'b0, dsp_data}, 8'h0D);
        checkOutput("dsp_valid_set", {7'b0, dsp_valid}, 8'h01);
        busRead(16'hD012, 8'h8D, "dsp_busy");
        dsp_ready = 1'b1;
        applyStimulus(IDLE_ADDR, 1'b0, 8'h00);
        dsp_ready = 1'b0;
        checkOutput("dsp_valid_clr", {7'b0, dsp_valid}, 8'h00);
        busRead(16'hD012, 8'h0D, "dsp_idle");

        // Write coinciding with handshake is dropped
        applyStimulus(16'hD012, 1'b1, 8'h8A);
        dsp_ready = 1'b1;
        applyStimulus(16'hD012, 1'b1, 8'hC1);
        dsp_ready = 1'b0;
        checkOutput("hs_wr_valid", {7'b0, dsp_valid}, 8'h00);
        checkOutput("hs_wr_data", {1'b0, dsp_data}, 8'h0A);
        busRead(16'hD012, 8'h0A, "dsp_after_hs");

        // Control registers keep only bits 6:0; KBD writes ignored
        applyStimulus(16'hD011, 1'b1, 8'hA7);
        applyStimulus(16'hD013, 1'b1, 8'hA7);
        busRead(16'hD011, 8'h27, "kbdcr_wr");
        busRead(16'hD013, 8'h27, "dspcr_wr");
        applyStimulus(16'hD010, 1'b1, 8'hFF);
        busRead(16'hD011, 8'h27, "kbd_wr_ignored");
        busRead(16'hD010, 8'h00, "kbd_still_empty");

        // Simultaneous push and pop with two entries queued
        pushKey(7'h78);
        pushKey(7'h79);
        kbd_data  = 7'h5A;
        kbd_valid = 1'b1;
        busRead(16'hD010, 8'hD8, "pushpop_head");
        kbd_valid = 1'b0;
        busRead(16'hD011, 8'hA7, "pushpop_nonempty");
        busRead(16'hD010, 8'hD9, "pushpop_y");
        busRead(16'hD010, 8'hDA, "pushpop_z");
        busRead(16'hD011, 8'h27, "pushpop_empty");

        // Push and pop on an empty FIFO: push lands, read returns zero
        kbd_data  = 7'h31;
        kbd_valid = 1'b1;
        busRead(16'hD010, 8'h00, "empty_pushpop");
        kbd_valid = 1'b0;
        busRead(16'hD010, 8'hB1, "empty_push_landed");
        busRead(16'hD011, 8'h27, "empty_again");

        // Reset mid-stream
        pushKey(7'h71);
        applyStimulus(16'hD012, 1'b1, 8'h8D);
        checkOutput("pre_rst_valid", {7'b0, dsp_valid}, 8'h01);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("mid_rst_valid", {7'b0, dsp_valid}, 8'h00);
        checkOutput("mid_rst_data", {1'b0, dsp_data}, 8'h00);
        checkOutput("mid_rst_ready", {7'b0, kbd_ready}, 8'h00);
        checkOutput("mid_rst_sel", {7'b0, pia_sel}, 8'h00);
        busRead(16'hD011, 8'h00, "post_rst_kbdcr");
        busRead(16'hD010, 8'h00, "post_rst_kbd");
        busRead(16'hD012, 8'h00, "post_rst_dsp");
        busRead(16'hD013, 8'h00, "post_rst_dspcr");

        // Accesses just outside the window
        applyStimulus(16'hD013, 1'b1, 8'h15);
        busRead(16'hD013, 8'h15, "dspcr_15");
        applyStimulus(16'hD014, 1'b0, 8'h00);
        checkOutput("d014_sel", {7'b0, pia_sel}, 8'h00);
        checkOutput("d014_di_hold", pia_DI, 8'h15);
        applyStimulus(16'hD00F, 1'b0, 8'h00);
        checkOutput("d00f_sel", {7'b0, pia_sel}, 8'h00);
        applyStimulus(16'hD00F, 1'b1, 8'hFF);
        applyStimulus(16'hD014, 1'b1, 8'hFF);
        checkOutput("oob_wr_valid", {7'b0, dsp_valid}, 8'h00);
        busRead(16'hD013, 8'h15, "oob_dspcr");
        busRead(16'hD012, 8'h00, "oob_dsp");
        busRead(16'hD011, 8'h00, "oob_kbdcr");

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
